// File: rtl/ddr3_read_responder.sv
// ddr3_read_responder
// Read engine between the layer sequencer and the DDR3 controller's Avalon-MM
// port. Word reads are issued one per cycle, tracked while in flight, and
// returned in request order through a response FIFO. A credit count covers
// every request from acceptance until its word is popped, so the FIFO cannot
// overflow. A flush pulse abandons all pending work and drains in-flight reads.
//
// Build option: define DDR3_READ_PERF_EN to build the saturating read_count
// and stall_count counters; otherwise both outputs are tied to zero.
`timescale 1ns/1ps

module ddr3_read_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    input  logic                  flush,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] avm_address,
    output logic                  avm_read,
    input  logic                  avm_waitrequest,
    input  logic [DATA_WIDTH-1:0] avm_readdata,
    input  logic                  avm_readdatavalid,
    output logic [31:0]           read_count,
    output logic [31:0]           stall_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]            state;
    logic [CW-1:0]         inflight;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         used;
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] req_addr_aligned;

    logic accept;
    logic issue;
    logic ret;
    logic push;
    logic pop;
    logic flush_take;

    assign req_addr_aligned = req_addr & ~ADDR_WIDTH'(3);

    // A read still waiting on the bus holds one credit, as does each read in
    // flight and each buffered word.
    assign used = CW'(avm_read) + inflight + fifo_count;

    // NOTE: reset is folded in so req_ready reads 0 while reset is asserted,
    // even though the registered state already reads RUN.
    assign req_ready = reset && (state == ST_RUN) && (used < DEPTH_C)
                       && (!avm_read || !avm_waitrequest);

    assign accept     = req_valid && req_ready;
    assign issue      = avm_read && !avm_waitrequest;
    assign ret        = avm_readdatavalid && (inflight != '0);
    assign flush_take = flush && (state == ST_RUN);
    assign push       = ret && (state == ST_RUN) && !flush;
    assign rsp_valid  = (state == ST_RUN) && (fifo_count != '0);
    assign pop        = rsp_valid && rsp_ready;
    assign rsp_data   = rsp_valid ? mem[rd_ptr] : '0;
    assign busy       = avm_read || (inflight != '0) || (fifo_count != '0)
                        || (state == ST_FLUSH);

    // Run/flush state: leave FLUSH once the bus is quiet and nothing is in flight.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN:   if (flush) state <= ST_FLUSH;
                ST_FLUSH: if (!avm_read && (inflight == '0)) state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    // Avalon request register: load on accept, hold while stalled, drop after issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            avm_read    <= 1'b0;
            avm_address <= '0;
        end else if (accept) begin
            avm_read    <= 1'b1;
            avm_address <= req_addr_aligned;
        end else if (issue) begin
            avm_read <= 1'b0;
            if (state == ST_FLUSH) avm_address <= '0;
        end
    end

    // In-flight counter: issued reads not yet returned; stray returns are ignored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({issue, ret})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Response FIFO pointers and occupancy; a flush empties it at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush_take) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // FIFO storage write port.
    // NOTE: the array has no reset; rsp_data is gated by rsp_valid, so stale
    // contents are never visible.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= avm_readdata;
    end

`ifdef DDR3_READ_PERF_EN
    // Saturating performance counters, cleared by reset and by an accepted flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_count  <= '0;
            stall_count <= '0;
        end else if (flush_take) begin
            read_count  <= '0;
            stall_count <= '0;
        end else begin
            if (pop && (read_count != '1)) read_count <= read_count + 32'd1;
            if (avm_read && avm_waitrequest && (stall_count != '1))
                stall_count <= stall_count + 32'd1;
        end
    end
`else
    assign read_count  = '0;
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_ddr3_read_responder.sv
// Self-checking bench for ddr3_read_responder. A behavioural Avalon slave
// returns a known word per address after a programmable latency; expected
// words are queued when a request is accepted and compared on each pop.
`timescale 1ns/1ps

module tb_ddr3_read_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
`ifdef DDR3_READ_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] rsp_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          flush;
    logic          busy;
    logic [AW-1:0] avm_address;
    logic          avm_read;
    logic          avm_waitrequest;
    logic [DW-1:0] avm_readdata;
    logic          avm_readdatavalid;
    logic [31:0]   read_count;
    logic [31:0]   stall_count;

    typedef struct {
        int          due;
        logic [31:0] data;
    } ret_t;

    ret_t        ret_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int          lat      = 5;
    int          wr_hold  = 0;

    ddr3_read_responder #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .rsp_data          (rsp_data),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .flush             (flush),
        .busy              (busy),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .read_count        (read_count),
        .stall_count       (stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int k;
        k = 0;
        while (busy && (k < limit)) begin
            step();
            k++;
        end
        check(tag, busy, 1'b0);
    endtask

    // Avalon slave: stalls on request, returns each issued read after lat cycles.
    initial begin
        avm_waitrequest   = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        forever begin
            @(negedge clock);
            cyc++;
            avm_readdatavalid = 1'b0;
            avm_readdata      = '0;
            if ((ret_q.size() > 0) && (ret_q[0].due == cyc)) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = ret_q[0].data;
                void'(ret_q.pop_front());
            end
            if (avm_read && (wr_hold > 0)) begin
                avm_waitrequest = 1'b1;
                wr_hold--;
            end else begin
                avm_waitrequest = 1'b0;
            end
            if (avm_read && !avm_waitrequest)
                ret_q.push_back('{cyc + lat, data_of(avm_address)});
        end
    end

    // Scoreboard: push on accept, pop and compare on each response handshake.
    initial begin
        forever begin
            @(negedge clock);
            #2;
            if (!reset || flush) begin
                exp_q.delete();
            end else begin
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) check("rsp_unexpected", 64'(exp_q.size()), 64'd1);
                    else check("rsp_data", rsp_data, exp_q.pop_front());
                end
                if (req_valid && req_ready)
                    exp_q.push_back(data_of({req_addr[31:2], 2'b00}));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        bit seen;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b0;
        flush     = 1'b0;
        step();
        step();

        // Reset values
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_avm_read", avm_read, 1'b0);
        check("rst_avm_address", avm_address, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_read_count", read_count, 32'h0);
        check("rst_stall_count", stall_count, 32'h0);
        step();
        reset = 1'b1;
        step();

        // Single read, latency 5
        lat       = 5;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0104;
        step();
        req_valid = 1'b0;
        check("t1_avm_read", avm_read, 1'b1);
        check("t1_avm_address", avm_address, 32'h0000_0104);
        k = 0;
        while (!rsp_valid && (k < 40)) begin
            step();
            k++;
        end
        check("t1_latency", k, 6);
        check("t1_rsp_data", rsp_data, 32'hFEFB_0104);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        wait_idle("t1_idle", 40);

        // 16 back-to-back requests fill the credits
        lat = 3;
        for (int i = 0; i < 16; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'(i * 4);
            check("t2_ready", req_ready, 1'b1);
            step();
        end
        req_addr = 32'h0000_0040;
        check("t2_full", req_ready, 1'b0);
        repeat (10) step();
        check("t2_full_hold", req_ready, 1'b0);
        check("t2_rsp_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("t2_reopen", req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("t2_idle", 100);
        rsp_ready = 1'b0;
        check("t2_sb_empty", 64'(exp_q.size()), 64'd0);

        // Waitrequest held 3 cycles on the second request
        lat       = 4;
        req_valid = 1'b1;
        req_addr  = 32'h0000_0300;
        step();
        req_addr = 32'h0000_0304;
        wr_hold  = 3;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t3_avm_read", avm_read, 1'b1);
            check("t3_avm_address", avm_address, 32'h0000_0304);
            check("t3_ready_stall", req_ready, 1'b0);
            step();
        end
        rsp_ready = 1'b1;
        wait_idle("t3_idle", 60);
        rsp_ready = 1'b0;
        check("t3_stall_count", stall_count, PERF ? 32'd3 : 32'd0);
        check("t3_sb_empty", 64'(exp_q.size()), 64'd0);

        // Unaligned address is forced to a word boundary
        req_valid = 1'b1;
        req_addr  = 32'h0000_0007;
        step();
        req_valid = 1'b0;
        check("t4_avm_address", avm_address, 32'h0000_0004);
        rsp_ready = 1'b1;
        wait_idle("t4_idle", 40);
        rsp_ready = 1'b0;

        // Flush with 3 buffered and 4 in flight
        lat = 8;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0000_0400 + 32'(i * 4);
            step();
        end
        req_valid = 1'b0;
        repeat (12) step();
        check("t5_buffered", rsp_valid, 1'b1);
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0000_0500 + 32'(i * 4);
            step();
        end
        req_valid = 1'b0;
        step();
        check("t5_avm_read_done", avm_read, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t5_rsp_valid", rsp_valid, 1'b0);
        check("t5_ready_flush", req_ready, 1'b0);
        check("t5_busy_flush", busy, 1'b1);
        seen = 1'b0;
        k    = 0;
        while (busy && (k < 40)) begin
            step();
            k++;
            if (rsp_valid) seen = 1'b1;
        end
        check("t5_idle", busy, 1'b0);
        check("t5_no_rsp", seen, 1'b0);
        check("t5_read_count", read_count, 32'h0);
        check("t5_ready_back", req_ready, 1'b1);
        req_valid = 1'b1;
        req_addr  = 32'h0000_0600;
        step();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_idle("t5_after_idle", 40);
        rsp_ready = 1'b0;
        check("t5_read_count_after", read_count, PERF ? 32'd1 : 32'd0);
        check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

        // Zero-length flush
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("zf_busy", busy, 1'b1);
        check("zf_ready", req_ready, 1'b0);
        step();
        check("zf_busy_done", busy, 1'b0);
        check("zf_ready_back", req_ready, 1'b1);

        // Reset with 5 in flight, then late returns
        lat = 10;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1;
            req_addr  = 32'h0000_0700 + 32'(i * 4);
            step();
        end
        req_valid = 1'b0;
        step();
        check("t6_busy_pre", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("t6_req_ready", req_ready, 1'b0);
        check("t6_rsp_valid", rsp_valid, 1'b0);
        check("t6_rsp_data", rsp_data, 32'h0);
        check("t6_avm_read", avm_read, 1'b0);
        check("t6_avm_address", avm_address, 32'h0);
        check("t6_busy", busy, 1'b0);
        check("t6_read_count", read_count, 32'h0);
        check("t6_stall_count", stall_count, 32'h0);
        step();
        reset = 1'b1;
        seen  = 1'b0;
        repeat (20) begin
            step();
            if (rsp_valid || busy) seen = 1'b1;
        end
        check("t6_no_rsp", seen, 1'b0);
        check("t6_ready_after", req_ready, 1'b1);
        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
